// File: rtl/output_arbiter_if.sv
// output_arbiter_if: bundle of head flits, pops, registered output flit
// and credit return for one output port of the mesh router.
interface output_arbiter_if #(
  parameter int NUM_IN = 5
);
  logic [23*NUM_IN-1:0] in_flit;
  logic [NUM_IN-1:0]    pop;
  logic [22:0]          out_flit;
  logic                 out_valid;
  logic                 credit_in;
  logic                 credit_err;

  // Upstream FIFOs plus downstream consumer side
  modport master (
    output in_flit,
    output credit_in,
    input  pop,
    input  out_flit,
    input  out_valid,
    input  credit_err
  );

  // Arbiter side
  modport slave (
    input  in_flit,
    input  credit_in,
    output pop,
    output out_flit,
    output out_valid,
    output credit_err
  );
endinterface

// File: rtl/output_arbiter.sv
// output_arbiter: round-robin switch allocator for one output port.
// Picks one head flit whose target equals PORT_ID, pops it combinationally
// and registers it onto out_flit one cycle later.
// Define OUTPUT_ARBITER_CREDIT_EN to enable the downstream credit counter,
// credit_in and sticky credit_err; otherwise every request is eligible.
module output_arbiter #(
  parameter int          NUM_IN  = 5,
  parameter logic [2:0]  PORT_ID = 3'd0,
  parameter int          DEPTH   = 4
) (
  input  logic           clk,
  input  logic           RST,
  output_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [22:0]      out_flit_q, out_flit_d;
  logic             out_valid_q, out_valid_d;
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] elig;
  logic             found;
  logic [PTR_W-1:0] win;
  logic [22:0]      win_flit;
  logic             grant;
  logic             credit_ok;

`ifdef OUTPUT_ARBITER_CREDIT_EN
  logic [2:0] credits_q, credits_d;
  logic       credit_err_q, credit_err_d;

  assign credit_ok = (credits_q != 3'd0);
`else
  logic [3:0] unused_cfg;

  assign credit_ok  = 1'b1;
  assign unused_cfg = {bus.credit_in, 3'(DEPTH)};
`endif

  // Request decode: non-empty head whose target selects this port
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      req[i] = (bus.in_flit[23*i +: 23] != 23'd0) &&
               (bus.in_flit[23*i +: 3] == PORT_ID);
    end
    elig = credit_ok ? req : '0;
  end

  // Round-robin search starting at ptr; first eligible index wins
  always_comb begin
    int unsigned idx;
    found    = 1'b0;
    win      = '0;
    win_flit = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!found && elig[idx]) begin
        found    = 1'b1;
        win      = PTR_W'(idx);
        win_flit = bus.in_flit[23*idx +: 23];
      end
    end
    // A grant decided while RST is high is dropped so no flit is lost
    grant = found && !RST;
  end

  // Pop and next-state for the output register and pointer
  always_comb begin
    bus.pop     = '0;
    ptr_d       = ptr_q;
    out_flit_d  = out_flit_q;
    out_valid_d = 1'b0;
    if (grant) begin
      bus.pop[win] = 1'b1;
      out_flit_d   = win_flit;
      out_valid_d  = 1'b1;
      ptr_d        = (win == PTR_W'(NUM_IN - 1)) ? '0 : win + 1'b1;
    end
  end

`ifdef OUTPUT_ARBITER_CREDIT_EN
  // Credit counter: grant consumes, credit_in returns; overflow is sticky
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (grant && bus.credit_in) begin
      credits_d = credits_q;
    end else if (grant) begin
      credits_d = credits_q - 3'd1;
    end else if (bus.credit_in) begin
      if (credits_q == 3'(DEPTH)) credit_err_d = 1'b1;
      else                        credits_d    = credits_q + 3'd1;
    end
  end

  // Credit state registers
  always_ff @(posedge clk) begin
    if (RST) begin
      credits_q    <= 3'(DEPTH);
      credit_err_q <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign bus.credit_err = credit_err_q;
`else
  assign bus.credit_err = 1'b0;
`endif

  // Output flit, valid and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (RST) begin
      ptr_q       <= '0;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_flit_q  <= out_flit_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_flit  = out_flit_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_output_arbiter.sv
// Directed self-checking bench for output_arbiter (NUM_IN=5, PORT_ID=2, DEPTH=4).
module tb_output_arbiter;
  localparam int         NUM_IN  = 5;
  localparam logic [2:0] PORT_ID = 3'd2;
  localparam int         DEPTH   = 4;

  logic clk = 1'b0;
  logic RST;
  int   tests_run    = 0;
  int   tests_failed = 0;

  output_arbiter_if #(.NUM_IN(NUM_IN)) bus ();

  output_arbiter #(.NUM_IN(NUM_IN), .PORT_ID(PORT_ID), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [22:0] mk(input logic [15:0] d, input logic [3:0] a, input logic [2:0] t);
    return {d, a, t};
  endfunction

  task automatic set_in(input int i, input logic [22:0] f);
    bus.in_flit[23*i +: 23] = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST           = 1'b1;
    bus.credit_in = 1'b0;
    for (int i = 0; i < NUM_IN; i++) set_in(i, mk(16'h1111 + 16'(i), 4'h1, PORT_ID));
    #1;
    tests_run++;
    if (bus.pop !== 5'b00000) begin tests_failed++; $display("FAIL reset_pop: got %b expected 00000", bus.pop); end
    tick();
    tick();
    tests_run++;
    if (bus.pop !== 5'b00000) begin tests_failed++; $display("FAIL reset_pop2: got %b expected 00000", bus.pop); end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    tests_run++;
    if (bus.out_flit !== 23'h0) begin tests_failed++; $display("FAIL reset_flit: got %h expected 000000", bus.out_flit); end
    tests_run++;
    if (bus.credit_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", bus.credit_err); end
    bus.in_flit = '0;
    RST = 1'b0;
  endtask

  task automatic test_single_request();
    do_reset();
    set_in(3, mk(16'hABCD, 4'h5, 3'd2));
    #1;
    tests_run++;
    if (bus.pop !== 5'b01000) begin tests_failed++; $display("FAIL single_pop: got %b expected 01000", bus.pop); end
    tick();
    tests_run++;
    if (bus.out_flit !== 23'h55E6AA) begin tests_failed++; $display("FAIL single_flit: got %h expected 55e6aa", bus.out_flit); end
    tests_run++;
    if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
    // pointer now at 4: with 0,3,4 requesting, 4 must win, then 0
    set_in(0, mk(16'h0001, 4'h1, 3'd2));
    set_in(4, mk(16'h4444, 4'h4, 3'd2));
    #1;
    tests_run++;
    if (bus.pop !== 5'b10000) begin tests_failed++; $display("FAIL single_ptr4: got %b expected 10000", bus.pop); end
    tick();
    tests_run++;
    if (bus.out_flit !== 23'h222222) begin tests_failed++; $display("FAIL single_flit4: got %h expected 222222", bus.out_flit); end
    set_in(4, 23'h0);
    #1;
    tests_run++;
    if (bus.pop !== 5'b00001) begin tests_failed++; $display("FAIL single_wrap: got %b expected 00001", bus.pop); end
    tick();
    tests_run++;
    if (bus.out_flit !== 23'h00008A) begin tests_failed++; $display("FAIL single_flit0: got %h expected 00008a", bus.out_flit); end
    bus.in_flit = '0;
    #1;
    tests_run++;
    if (bus.pop !== 5'b00000) begin tests_failed++; $display("FAIL single_idle_pop: got %b expected 00000", bus.pop); end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_idle_valid: got %b expected 0", bus.out_valid); end
    tests_run++;
    if (bus.out_flit !== 23'h00008A) begin tests_failed++; $display("FAIL single_hold: got %h expected 00008a", bus.out_flit); end
  endtask

  task automatic test_fairness();
    int          order [6] = '{0, 1, 4, 0, 1, 4};
    logic [22:0] fl    [5];
    fl[0] = mk(16'h0A0A, 4'h0, 3'd2);
    fl[1] = mk(16'h1B1B, 4'h1, 3'd2);
    fl[2] = 23'h0;
    fl[3] = 23'h0;
    fl[4] = mk(16'h4C4C, 4'h4, 3'd2);
    do_reset();
    for (int i = 0; i < NUM_IN; i++) set_in(i, fl[i]);
    bus.credit_in = 1'b1;
    for (int j = 0; j < 6; j++) begin
      #1;
      tests_run++;
      if (bus.pop !== 5'(1 << order[j])) begin
        tests_failed++; $display("FAIL rr_pop[%0d]: got %b expected %b", j, bus.pop, 5'(1 << order[j]));
      end
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_flit !== fl[order[j]]) begin
        tests_failed++; $display("FAIL rr_out[%0d]: got %b/%h expected 1/%h", j, bus.out_valid, bus.out_flit, fl[order[j]]);
      end
    end
    bus.credit_in = 1'b0;
    bus.in_flit   = '0;
  endtask

  task automatic test_target_filter();
    do_reset();
    set_in(0, mk(16'hBEEF, 4'h3, 3'd3));
    set_in(1, 23'h0);
    #1;
    tests_run++;
    if (bus.pop !== 5'b00000) begin tests_failed++; $display("FAIL filter_pop: got %b expected 00000", bus.pop); end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL filter_valid: got %b expected 0", bus.out_valid); end
    tests_run++;
    if (bus.out_flit !== 23'h0) begin tests_failed++; $display("FAIL filter_flit: got %h expected 000000", bus.out_flit); end
    bus.in_flit = '0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_in(2, mk(16'h2222, 4'h2, 3'd2));
    RST = 1'b1;
    #1;
    tests_run++;
    if (bus.pop !== 5'b00000) begin tests_failed++; $display("FAIL mid_pop: got %b expected 00000", bus.pop); end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_flit !== 23'h0) begin
      tests_failed++; $display("FAIL mid_out: got %b/%h expected 0/000000", bus.out_valid, bus.out_flit);
    end
    RST = 1'b0;
    #1;
    tests_run++;
    if (bus.pop !== 5'b00100) begin tests_failed++; $display("FAIL mid_resume_pop: got %b expected 00100", bus.pop); end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_flit !== 23'h111112) begin
      tests_failed++; $display("FAIL mid_resume_out: got %b/%h expected 1/111112", bus.out_valid, bus.out_flit);
    end
    bus.in_flit = '0;
  endtask

`ifdef OUTPUT_ARBITER_CREDIT_EN
  task automatic test_credit_exhaustion();
    do_reset();
    set_in(0, mk(16'h00C0, 4'h6, 3'd2));
    for (int j = 0; j < 8; j++) begin
      #1;
      tests_run++;
      if (bus.pop !== ((j < 4) ? 5'b00001 : 5'b00000)) begin
        tests_failed++; $display("FAIL exh_pop[%0d]: got %b expected %b", j, bus.pop, (j < 4) ? 5'b00001 : 5'b00000);
      end
      tick();
      tests_run++;
      if (bus.out_valid !== (j < 4)) begin
        tests_failed++; $display("FAIL exh_valid[%0d]: got %b expected %b", j, bus.out_valid, (j < 4));
      end
    end
    bus.credit_in = 1'b1;
    #1;
    tests_run++;
    if (bus.pop !== 5'b00000) begin tests_failed++; $display("FAIL exh_same_cycle: got %b expected 00000", bus.pop); end
    tick();
    bus.credit_in = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL exh_same_valid: got %b expected 0", bus.out_valid); end
    #1;
    tests_run++;
    if (bus.pop !== 5'b00001) begin tests_failed++; $display("FAIL exh_refill_pop: got %b expected 00001", bus.pop); end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL exh_refill_valid: got %b expected 1", bus.out_valid); end
    #1;
    tests_run++;
    if (bus.pop !== 5'b00000) begin tests_failed++; $display("FAIL exh_stall_pop: got %b expected 00000", bus.pop); end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL exh_stall_valid: got %b expected 0", bus.out_valid); end
    bus.in_flit = '0;
  endtask

  task automatic test_credit_overflow();
    // grant together with credit_in at full credits: net zero, no error
    do_reset();
    set_in(1, mk(16'h0101, 4'h1, 3'd2));
    bus.credit_in = 1'b1;
    tick();
    bus.credit_in = 1'b0;
    bus.in_flit   = '0;
    tests_run++;
    if (bus.credit_err !== 1'b0) begin tests_failed++; $display("FAIL ovf_grant_err: got %b expected 0", bus.credit_err); end
    do_reset();
    bus.credit_in = 1'b1;
    tick();
    bus.credit_in = 1'b0;
    tests_run++;
    if (bus.credit_err !== 1'b1) begin tests_failed++; $display("FAIL ovf_err: got %b expected 1", bus.credit_err); end
    tick();
    tick();
    tests_run++;
    if (bus.credit_err !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b expected 1", bus.credit_err); end
    set_in(0, mk(16'h0F0F, 4'h0, 3'd2));
    for (int j = 0; j < 5; j++) begin
      #1;
      tests_run++;
      if (bus.pop !== ((j < 4) ? 5'b00001 : 5'b00000)) begin
        tests_failed++; $display("FAIL ovf_credits[%0d]: got %b expected %b", j, bus.pop, (j < 4) ? 5'b00001 : 5'b00000);
      end
      tick();
    end
    bus.in_flit = '0;
    tests_run++;
    if (bus.credit_err !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky2: got %b expected 1", bus.credit_err); end
    do_reset();
    tests_run++;
    if (bus.credit_err !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %b expected 0", bus.credit_err); end
  endtask
`else
  task automatic test_credit_disabled();
    do_reset();
    bus.credit_in = 1'b1;
    tick();
    bus.credit_in = 1'b0;
    tests_run++;
    if (bus.credit_err !== 1'b0) begin tests_failed++; $display("FAIL nocred_err: got %b expected 0", bus.credit_err); end
    set_in(0, mk(16'h00C0, 4'h6, 3'd2));
    for (int j = 0; j < 8; j++) begin
      #1;
      tests_run++;
      if (bus.pop !== 5'b00001) begin tests_failed++; $display("FAIL nocred_pop[%0d]: got %b expected 00001", j, bus.pop); end
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL nocred_valid[%0d]: got %b expected 1", j, bus.out_valid); end
    end
    bus.in_flit = '0;
    tests_run++;
    if (bus.credit_err !== 1'b0) begin tests_failed++; $display("FAIL nocred_err2: got %b expected 0", bus.credit_err); end
  endtask
`endif

  initial begin
    bus.in_flit   = '0;
    bus.credit_in = 1'b0;
    test_reset();
    test_single_request();
    test_fairness();
    test_target_filter();
    test_reset_midstream();
`ifdef OUTPUT_ARBITER_CREDIT_EN
    test_credit_exhaustion();
    test_credit_overflow();
`else
    test_credit_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/output_arbiter.md
# output_arbiter

Per-output-port switch allocator for the mesh router. Sits directly downstream of the per-port input FIFOs: it inspects each FIFO's head flit, picks one whose target field selects this output port using round-robin arbitration, pops that FIFO, and registers the flit toward the link or the neighbouring router's input FIFO. A credit counter mirrors the downstream FIFO occupancy so no flit is ever sent into a full buffer.

## Interface
Parameters:
- NUM_IN, 5, number of input FIFOs competing for this port (2..8)
- PORT_ID, 3'd0, 3-bit target code served by this port
- DEPTH, 4, downstream FIFO depth and initial credit count (1..7)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- in_flit  input  23*NUM_IN  head flits; flit i at [23*i+22:23*i]; bits 22:7 data, 6:3 addr, 2:0 target
- pop  output  NUM_IN  one-hot (or zero) pop to input FIFOs, combinational
- out_flit  output  23  registered granted flit
- out_valid  output  1  out_flit holds a new flit this cycle
- credit_in  input  1  downstream freed one slot (one pulse = one credit)
- credit_err  output  1  sticky: credit returned while counter already at DEPTH

## Operation
- Request i = (in_flit[i] != 23'b0) && (in_flit[i][2:0] == PORT_ID). An all-zero flit is empty and never requests.
- Eligible = request && credits != 0.
- Round-robin: pointer ptr (0..NUM_IN-1). Search order ptr, ptr+1, ..., wrapping mod NUM_IN; first eligible index wins. At most one grant per cycle.
- pop[w] = 1 for winner w in the same cycle; all other pop bits 0. No pop ever asserted for an empty or non-requesting head.
- On grant edge: out_flit <= in_flit[w], out_valid <= 1, ptr <= (w+1) mod NUM_IN, credits <= credits-1 (+1 if credit_in).
- No grant: out_valid <= 0, out_flit holds last value, ptr unchanged, credits <= credits + credit_in.
- credit_in with credits == DEPTH and no grant that cycle: credits stays DEPTH, credit_err <= 1 (sticky until RST).
- Flit forwarded unmodified; no addr/target rewriting.

## Timing
- Reset (RST high at an edge): out_flit = 0, out_valid = 0, ptr = 0, credits = DEPTH, credit_err = 0. pop forced to 0 while RST is high.
- Latency: flit present at head in cycle N -> pop high in N -> out_flit/out_valid valid in N+1.
- Throughput: one flit per cycle while credits last; back-to-back grants allowed.
- Credits 0: no pop, no out_valid until credit_in; credit_in in cycle N makes a grant possible in N+1.
- Credit 0 and credit_in in same cycle: no grant that cycle (eligibility uses registered credits).
- Grant and credit_in in same cycle: net counter change 0.
- Reset mid-stream: any grant decided in the reset cycle is discarded; pop not asserted, so no flit is lost.

## Configuration
- OUTPUT_ARBITER_CREDIT_EN defined: credit counter, credit_in and credit_err behave as above.
- Not defined: credits logic removed; every requesting head is eligible every cycle, credit_in ignored, credit_err tied 0. Used when the downstream consumer always accepts.

## Test plan
- Reset: RST high 2 cycles with in_flit nonzero -> pop = 0, out_valid = 0, out_flit = 0, credit_err = 0.
- Single request: NUM_IN=5, PORT_ID=2, in_flit[3] = {16'hABCD,4'h5,3'd2} -> pop = 5'b01000 same cycle, next cycle out_flit = 23'h55E6AA... (exact {16'hABCD,4'h5,3'd2}), out_valid = 1, ptr = 4.
- Round-robin fairness: inputs 0,1,4 all request target 2 continuously, credits replenished every cycle -> grant order 0,1,4,0,1,4.
- Target filter: in_flit[0] target 3, in_flit[1] = 0 -> pop = 0, out_valid stays 0.
- Credit exhaustion: DEPTH=4, no credit_in, input 0 holds 6 flits -> exactly 4 pops/out_valid pulses, then stall; one credit_in pulse -> exactly one more flit one cycle later.
- Credit overflow: after reset, pulse credit_in with no traffic -> credits stay 4, credit_err = 1 and remains 1 until RST.
